// File: rtl/tx_prbs_source_if.sv
// tx_prbs_source_if: control/status bundle between the system control registers and tx_prbs_source
//   master: drives i_en_tx, i_en_rate1, i_start, i_stop, i_err_period, i_err_en_I, i_err_en_Q
//   slave : drives o_tx_bit_I, o_tx_bit_Q, o_tx_valid, o_period_start, o_err_inj_cnt_I/Q, o_tx_cnt
interface tx_prbs_source_if #(parameter int ERR_PER_W = 16);
  logic i_en_tx;
  logic i_en_rate1;
  logic i_start;
  logic i_stop;
  logic [ERR_PER_W-1:0] i_err_period;
  logic i_err_en_I;
  logic i_err_en_Q;
  logic o_tx_bit_I;
  logic o_tx_bit_Q;
  logic o_tx_valid;
  logic o_period_start;
  logic [31:0] o_err_inj_cnt_I;
  logic [31:0] o_err_inj_cnt_Q;
  logic [63:0] o_tx_cnt;
  modport master (
    output i_en_tx, i_en_rate1, i_start, i_stop, i_err_period, i_err_en_I, i_err_en_Q,
    input o_tx_bit_I, o_tx_bit_Q, o_tx_valid, o_period_start, o_err_inj_cnt_I, o_err_inj_cnt_Q, o_tx_cnt
  );
  modport slave (
    input i_en_tx, i_en_rate1, i_start, i_stop, i_err_period, i_err_en_I, i_err_en_Q,
    output o_tx_bit_I, o_tx_bit_Q, o_tx_valid, o_period_start, o_err_inj_cnt_I, o_err_inj_cnt_Q, o_tx_cnt
  );
endinterface

// File: rtl/tx_prbs_source.sv
// tx_prbs_source: PRBS9 (x^9+x^5+1) I/Q bit source with per-branch error injection and bit counters
//   clk     : system clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : slave side of tx_prbs_source_if (enables, start/stop, injection control, bits and counters)
module tx_prbs_source #(
  parameter logic [8:0] PRBS_SEED_I = 9'h1AA,
  parameter logic [8:0] PRBS_SEED_Q = 9'h1FE,
  parameter int PRBS_MAX_CYCLES = 511,
  parameter int ERR_PER_W = 16
) (
  input logic clk,
  input logic i_reset,
  tx_prbs_source_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [8:0] lfsr_i, lfsr_q, p;
  logic [ERR_PER_W-1:0] c;
  logic adv, slot, inj_i, inj_q;
  always_comb begin
    adv = bus.i_en_tx & bus.i_en_rate1 & (state == RUN);
    slot = adv & (bus.i_err_period != '0) & (c == bus.i_err_period - 1'b1);
    inj_i = slot & bus.i_err_en_I;
    inj_q = slot & bus.i_err_en_Q;
  end
  always_ff @(posedge clk)
    if (!i_reset) begin
      state <= IDLE;
      lfsr_i <= PRBS_SEED_I;
      lfsr_q <= PRBS_SEED_Q;
      p <= '0;
      c <= '0;
      bus.o_tx_bit_I <= 1'b0;
      bus.o_tx_bit_Q <= 1'b0;
      bus.o_tx_valid <= 1'b0;
      bus.o_period_start <= 1'b0;
      bus.o_err_inj_cnt_I <= '0;
      bus.o_err_inj_cnt_Q <= '0;
      bus.o_tx_cnt <= '0;
    end else if (!bus.i_en_tx) begin
      bus.o_tx_valid <= 1'b0;
      bus.o_period_start <= 1'b0;
    end else begin
      bus.o_tx_valid <= adv;
      bus.o_period_start <= adv & (p == '0);
      if (adv) begin
        lfsr_i <= {lfsr_i[7:0], lfsr_i[8] ^ lfsr_i[4]};
        lfsr_q <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        p <= (p == 9'(PRBS_MAX_CYCLES - 1)) ? '0 : p + 1'b1;
        c <= (bus.i_err_period == '0 || slot) ? '0 : c + 1'b1;
        bus.o_tx_bit_I <= lfsr_i[8] ^ inj_i;
        bus.o_tx_bit_Q <= lfsr_q[8] ^ inj_q;
        bus.o_err_inj_cnt_I <= bus.o_err_inj_cnt_I + {31'd0, inj_i};
        bus.o_err_inj_cnt_Q <= bus.o_err_inj_cnt_Q + {31'd0, inj_q};
        bus.o_tx_cnt <= bus.o_tx_cnt + 64'd1;
      end
      if (state == IDLE && bus.i_start && !bus.i_stop)
        state <= RUN;
      // Stop is placed after the advance so its reload wins over the shift when both coincide.
      if (state == RUN && bus.i_stop) begin
        state <= IDLE;
        lfsr_i <= PRBS_SEED_I;
        lfsr_q <= PRBS_SEED_Q;
        p <= '0;
        c <= '0;
      end
    end
endmodule

// File: tb/tb_tx_prbs_source.sv
// tb_tx_prbs_source: directed self-checking bench for tx_prbs_source
module tb_tx_prbs_source;
  logic clk = 1'b0;
  logic i_reset;
  int checks = 0;
  int errors = 0;
  int pos;
  logic [15:0] cm;
  logic [63:0] exp_tx;
  logic [31:0] exp_ei, exp_eq;
  logic last_i, last_q;
  logic g_i [0:1021];
  logic g_q [0:1021];
  tx_prbs_source_if #(.ERR_PER_W(16)) ifc ();
  tx_prbs_source dut (.clk(clk), .i_reset(i_reset), .bus(ifc));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    pos = 0;
    cm = '0;
  endtask
  task automatic expect_adv();
    logic slot;
    slot = (ifc.i_err_period != 0) && (cm == ifc.i_err_period - 16'd1);
    cm = (ifc.i_err_period == 0 || slot) ? 16'd0 : cm + 16'd1;
    last_i = g_i[pos % 1022] ^ (slot & ifc.i_err_en_I);
    last_q = g_q[pos % 1022] ^ (slot & ifc.i_err_en_Q);
    exp_ei += {31'd0, slot & ifc.i_err_en_I};
    exp_eq += {31'd0, slot & ifc.i_err_en_Q};
    exp_tx++;
    chk("valid", ifc.o_tx_valid, 1);
    chk("period_start", ifc.o_period_start, (pos % 511 == 0));
    chk("bit_I", ifc.o_tx_bit_I, last_i);
    chk("bit_Q", ifc.o_tx_bit_Q, last_q);
    chk("tx_cnt", ifc.o_tx_cnt, exp_tx);
    pos++;
  endtask
  task automatic adv_chk(input int n);
    ifc.i_en_rate1 = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      expect_adv();
    end
    ifc.i_en_rate1 = 1'b0;
  endtask
  task automatic pulse_start();
    ifc.i_start = 1'b1;
    tick();
    ifc.i_start = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_bit_I"}, ifc.o_tx_bit_I, 0);
    chk({tag, "_bit_Q"}, ifc.o_tx_bit_Q, 0);
    chk({tag, "_valid"}, ifc.o_tx_valid, 0);
    chk({tag, "_pstart"}, ifc.o_period_start, 0);
    chk({tag, "_inj_I"}, ifc.o_err_inj_cnt_I, 0);
    chk({tag, "_inj_Q"}, ifc.o_err_inj_cnt_Q, 0);
    chk({tag, "_tx_cnt"}, ifc.o_tx_cnt, 0);
  endtask
  initial begin
    logic [8:0] si, sq, vi, vq;
    si = 9'h1AA;
    sq = 9'h1FE;
    // Golden sequence from the bit recurrence b[n] = b[n-9] ^ b[n-5].
    for (int k = 0; k < 9; k++) begin
      g_i[k] = si[8-k];
      g_q[k] = sq[8-k];
    end
    for (int k = 9; k < 1022; k++) begin
      g_i[k] = g_i[k-9] ^ g_i[k-5];
      g_q[k] = g_q[k-9] ^ g_q[k-5];
    end
    i_reset = 1'b0;
    ifc.i_en_tx = 1'b0;
    ifc.i_en_rate1 = 1'b0;
    ifc.i_start = 1'b0;
    ifc.i_stop = 1'b0;
    ifc.i_err_period = '0;
    ifc.i_err_en_I = 1'b0;
    ifc.i_err_en_Q = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    model_reset();
    exp_tx = '0;
    exp_ei = '0;
    exp_eq = '0;
    i_reset = 1'b1;
    ifc.i_en_tx = 1'b1;
    ifc.i_en_rate1 = 1'b1;
    ifc.i_start = 1'b1;
    tick();
    ifc.i_start = 1'b0;
    chk("start_cycle_valid", ifc.o_tx_valid, 0);
    chk("start_cycle_cnt", ifc.o_tx_cnt, 0);
    vi = 9'b110101010;
    vq = 9'b111111110;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("first9_valid", ifc.o_tx_valid, 1);
      chk("first9_pstart", ifc.o_period_start, k == 0);
      chk("first9_I", ifc.o_tx_bit_I, vi[8-k]);
      chk("first9_Q", ifc.o_tx_bit_Q, vq[8-k]);
    end
    ifc.i_en_rate1 = 1'b0;
    chk("first9_cnt", ifc.o_tx_cnt, 9);
    pos = 9;
    exp_tx = 9;
    adv_chk(1013);
    chk("two_period_cnt", ifc.o_tx_cnt, 1022);
    ifc.i_err_period = 16'd4;
    ifc.i_err_en_I = 1'b1;
    adv_chk(511);
    chk("inj_cnt_I", ifc.o_err_inj_cnt_I, 127);
    chk("inj_cnt_Q", ifc.o_err_inj_cnt_Q, 0);
    ifc.i_err_period = '0;
    ifc.i_err_en_I = 1'b0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      ifc.i_en_rate1 = (cyc % 4 == 0);
      ifc.i_en_tx = !(cyc >= 5 && cyc < 15);
      tick();
      if (ifc.i_en_rate1 && ifc.i_en_tx)
        expect_adv();
      else begin
        chk("gap_valid", ifc.o_tx_valid, 0);
        chk("gap_hold_I", ifc.o_tx_bit_I, last_i);
        chk("gap_hold_Q", ifc.o_tx_bit_Q, last_q);
        chk("gap_cnt", ifc.o_tx_cnt, exp_tx);
      end
    end
    ifc.i_en_rate1 = 1'b0;
    ifc.i_en_tx = 1'b1;
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    chk_zero("reset2");
    model_reset();
    exp_tx = '0;
    exp_ei = '0;
    exp_eq = '0;
    pulse_start();
    adv_chk(100);
    ifc.i_stop = 1'b1;
    tick();
    ifc.i_stop = 1'b0;
    model_reset();
    ifc.i_en_rate1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stopped_valid", ifc.o_tx_valid, 0);
      chk("stopped_cnt", ifc.o_tx_cnt, 100);
    end
    ifc.i_en_rate1 = 1'b0;
    pulse_start();
    adv_chk(9);
    ifc.i_stop = 1'b1;
    tick();
    ifc.i_start = 1'b1;
    tick();
    ifc.i_start = 1'b0;
    ifc.i_stop = 1'b0;
    model_reset();
    ifc.i_en_rate1 = 1'b1;
    tick();
    tick();
    ifc.i_en_rate1 = 1'b0;
    chk("start_stop_valid", ifc.o_tx_valid, 0);
    chk("start_stop_cnt", ifc.o_tx_cnt, 109);
    pulse_start();
    ifc.i_err_period = 16'd1;
    ifc.i_err_en_Q = 1'b1;
    adv_chk(5);
    chk("inj_every_Q", ifc.o_err_inj_cnt_Q, 5);
    chk("inj_every_I", ifc.o_err_inj_cnt_I, 0);
    ifc.i_en_rate1 = 1'b1;
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    ifc.i_en_rate1 = 1'b0;
    chk_zero("reset_run");
    model_reset();
    exp_tx = '0;
    exp_ei = '0;
    exp_eq = '0;
    ifc.i_err_period = '0;
    ifc.i_err_en_Q = 1'b0;
    pulse_start();
    adv_chk(9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
